// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_if
// Description : Bundle of signals around alu_arbiter. It carries two requester
//               channels, the shared-ALU drive/return pair and the response
//               channel.
//               - slave  : the arbiter side.
//               - master : the environment side (requesters, ALU, consumer).
// Parameters  : WIDTH - operand/result width.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int WIDTH = 64
);
  // Requester channels
  logic             in0_valid;
  logic             in1_valid;
  logic [WIDTH-1:0] in0_a;
  logic [WIDTH-1:0] in0_b;
  logic [WIDTH-1:0] in1_a;
  logic [WIDTH-1:0] in1_b;
  logic [4:0]       in0_fsec;
  logic [4:0]       in1_fsec;
  logic             in0_carry;
  logic             in1_carry;
  logic             in0_ready;
  logic             in1_ready;
  // Shared ALU drive and combinational return
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [4:0]       alu_fsec;
  logic             alu_carry;
  logic [WIDTH-1:0] alu_fout;
  logic [3:0]       alu_signal;
  // Response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic [3:0]       rsp_signal;
  logic             rsp_err;

  modport slave (
    input  in0_valid, in1_valid, in0_a, in0_b, in1_a, in1_b,
           in0_fsec, in1_fsec, in0_carry, in1_carry,
           alu_fout, alu_signal, rsp_ready,
    output in0_ready, in1_ready, alu_a, alu_b, alu_fsec, alu_carry,
           rsp_valid, rsp_id, rsp_data, rsp_signal, rsp_err
  );

  modport master (
    output in0_valid, in1_valid, in0_a, in0_b, in1_a, in1_b,
           in0_fsec, in1_fsec, in0_carry, in1_carry,
           alu_fout, alu_signal, rsp_ready,
    input  in0_ready, in1_ready, alu_a, alu_b, alu_fsec, alu_carry,
           rsp_valid, rsp_id, rsp_data, rsp_signal, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : This module arbitrates between two requesters for one shared
//               combinational ALU.
//               - Arbitration is round-robin on ties.
//               - Operands are registered and issued in one EXEC cycle.
//               - The ALU result is captured and held in RESP until the
//                 consumer takes it.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - alu_arbiter_if.slave (requesters, ALU, response)
// Config      : ALU_ARB_OPCHECK_EN - when defined, an accepted opcode above
//               5'b10000 bypasses the ALU. It answers from IDLE straight into
//               RESP with rsp_err=1. When undefined, rsp_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH = 64
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  alu_arbiter_if.slave    bus
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic             r_rr_last;     // requester granted at the last accept
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [4:0]       r_op_fsec;
  logic             r_op_carry;
  logic             r_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic [3:0]       r_rsp_signal;

  logic             w_any_valid;
  logic             w_grant_id;
  logic             w_accept;
  logic             w_op_illegal;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [4:0]       w_sel_fsec;
  logic             w_sel_carry;

  // Arbitration: the lone valid requester wins. On a tie, the requester not
  // granted last time wins. With no valid requester the grant is a don't-care.
  assign w_any_valid = bus.in0_valid | bus.in1_valid;
  assign w_grant_id  = (bus.in0_valid && bus.in1_valid) ? ~r_rr_last : ~bus.in0_valid;
  assign w_accept    = (r_state == c_IDLE) && w_any_valid;

  assign w_sel_a     = w_grant_id ? bus.in1_a     : bus.in0_a;
  assign w_sel_b     = w_grant_id ? bus.in1_b     : bus.in0_b;
  assign w_sel_fsec  = w_grant_id ? bus.in1_fsec  : bus.in0_fsec;
  assign w_sel_carry = w_grant_id ? bus.in1_carry : bus.in0_carry;

`ifdef ALU_ARB_OPCHECK_EN
  logic r_rsp_err;
  assign w_op_illegal = (w_sel_fsec > 5'b10000);
  assign bus.rsp_err  = r_rsp_err;
`else
  assign w_op_illegal = 1'b0;
  assign bus.rsp_err  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: if (w_accept) w_next_state = w_op_illegal ? c_RESP : c_EXEC;
      c_EXEC: w_next_state = c_RESP;
      c_RESP: if (bus.rsp_ready) w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // Output logic: readies only in IDLE, and only toward the current winner.
  always_comb begin
    bus.in0_ready = 1'b0;
    bus.in1_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (r_state)
      c_IDLE: begin
        bus.in0_ready = w_any_valid && !w_grant_id;
        bus.in1_ready = w_any_valid &&  w_grant_id;
      end
      c_RESP:  bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture on accept, result capture at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last    <= 1'b1;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_fsec    <= '0;
      r_op_carry   <= 1'b0;
      r_id         <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_signal <= '0;
`ifdef ALU_ARB_OPCHECK_EN
      r_rsp_err    <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_id      <= w_grant_id;
        r_rr_last <= w_grant_id;
        // A rejected opcode never reaches the ALU, so the ALU inputs keep
        // the previous operands.
        if (!w_op_illegal) begin
          r_op_a     <= w_sel_a;
          r_op_b     <= w_sel_b;
          r_op_fsec  <= w_sel_fsec;
          r_op_carry <= w_sel_carry;
        end
`ifdef ALU_ARB_OPCHECK_EN
        r_rsp_err <= w_op_illegal;
        if (w_op_illegal) begin
          r_rsp_data   <= '0;
          r_rsp_signal <= '0;
        end
`endif
      end
      if (r_state == c_EXEC) begin
        r_rsp_data   <= bus.alu_fout;
        r_rsp_signal <= bus.alu_signal;
      end
    end
  end

  assign bus.alu_a      = r_op_a;
  assign bus.alu_b      = r_op_b;
  assign bus.alu_fsec   = r_op_fsec;
  assign bus.alu_carry  = r_op_carry;
  assign bus.rsp_id     = r_id;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_signal = r_rsp_signal;

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 64, data width of operands and result; SHALL be the only parameter.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in0_valid, in1_valid  input  1 each  requester N presents an operation.
REQ-005 in0_a, in0_b, in1_a, in1_b  input  WIDTH each  requester operands.
REQ-006 in0_fsec, in1_fsec  input  5 each  ALU opcode; in0_carry, in1_carry  input  1 each  carry-in.
REQ-007 in0_ready, in1_ready  output  1 each  operation accepted when valid&ready at clk edge.
REQ-008 alu_a, alu_b  output  WIDTH; alu_fsec  output  5; alu_carry  output  1; all drive the shared ALU.
REQ-009 alu_fout  input  WIDTH; alu_signal  input  4 (bit0 zero, bit1 negative, bit2 carry-out, bit3 signed overflow); combinational ALU return.
REQ-010 rsp_valid  output  1; rsp_ready  input  1; rsp_id  output  1 (winning requester); rsp_data  output  WIDTH; rsp_signal  output  4; rsp_err  output  1.

Function
REQ-011 FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-012 IDLE: at most one inN_ready SHALL be high, only for the arbitration winner whose inN_valid is high; both readies low in EXEC and RESP.
REQ-013 Arbitration: single valid requester wins; both valid -> requester not granted last time wins (round-robin); pointer updates only on accepted handshake.
REQ-014 On accept, a, b, fsec, carry and id SHALL be latched into operand registers; IDLE -> EXEC.
REQ-015 alu_a/alu_b/alu_fsec/alu_carry SHALL be driven solely from operand registers, holding last values outside EXEC.
REQ-016 EXEC lasts exactly one cycle; at its closing edge alu_fout and alu_signal captured into rsp_data/rsp_signal; EXEC -> RESP.
REQ-017 RESP: rsp_valid=1; rsp_data, rsp_signal, rsp_id, rsp_err stable until rsp_valid&rsp_ready; then -> IDLE.
REQ-018 Latency: accept edge to rsp_valid high = 2 cycles; minimum spacing between accepts = 3 cycles with rsp_ready held high.
REQ-019 rsp_ready high outside RESP SHALL be ignored; inN_valid deasserting outside IDLE SHALL have no effect.
REQ-020 A requester losing arbitration SHALL be granted at the next IDLE if still valid (no starvation).
REQ-021 No arithmetic in this block; results are ALU outputs passed unmodified, WIDTH bits, no truncation.

Reset
REQ-022 rst_n low SHALL immediately force: state IDLE, rsp_valid 0, rsp_data 0, rsp_signal 0, rsp_id 0, rsp_err 0, operand registers 0, round-robin pointer = requester 1 (so requester 0 wins first tie).
REQ-023 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response is produced for it.

Configuration
REQ-024 Macro ALU_ARB_OPCHECK_EN defined: accepted fsec > 5'b10000 SHALL skip EXEC, go IDLE -> RESP next cycle with rsp_data 0, rsp_signal 0, rsp_err 1; ALU operand registers not updated for it.
REQ-025 Macro undefined: every opcode SHALL be issued through EXEC unchanged; rsp_err tied 0.

Verification
REQ-026 Reset release, in0 only: a=5, b=3, fsec=00010 -> in0_ready 1 in IDLE, rsp_valid 2 cycles after accept, rsp_data=8, rsp_id=0, rsp_signal=0000.
REQ-027 Both valid continuously, rsp_ready=1: in0 fsec=00100 a=1, in1 fsec=00111 a=1 -> grants alternate 0,1,0,1; responses 2,0,2,0; rsp_signal bit0=1 on zero results.
REQ-028 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data held, both inN_ready 0; rsp_ready=1 -> return to IDLE next edge.
REQ-029 Overflow: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, fsec=00010 -> rsp_data=0, rsp_signal bit0=1, bit2=1.
REQ-030 rst_n pulsed low during RESP -> rsp_valid 0 immediately, no response delivered afterwards; next tie granted to requester 0.
REQ-031 fsec=5'b10101: with ALU_ARB_OPCHECK_EN -> rsp_err=1, rsp_data=0, rsp_valid 1 cycle after accept; without -> rsp_err=0, rsp_data=0 from ALU default, latency 2.
